// File: rtl/siso_pkg.sv
// Shared definitions for the round-robin SISO scheduler: FSM state encoding
// and a counter-width helper.
package siso_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // clog2 with a floor of one bit so zero/one-sized counters stay declarable
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/siso_rr_arb.sv
// Combinational round-robin arbiter: scans from the requester after last_grant
// upward with wrap and returns the first valid one, one-hot and encoded.
module siso_rr_arb
  import siso_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IW   = cnt_width(NREQ)
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [IW-1:0]   last_grant,
  input  logic            enable,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   grant_idx
);

  logic found;
  int   rot_idx;

  // Rotate so last_grant+1 has top priority, pick the first set bit, map back
  always_comb begin
    grant     = {NREQ{1'b0}};
    grant_idx = {IW{1'b0}};
    found     = 1'b0;
    rot_idx   = 0;
    for (int j = 0; j < NREQ; j++) begin
      rot_idx = (int'(last_grant) + 1 + j) % NREQ;
      if (enable && !found && req_valid[rot_idx]) begin
        found            = 1'b1;
        grant[rot_idx]   = 1'b1;
        grant_idx        = IW'(rot_idx);
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/siso_sched.sv
// Round-robin scheduler feeding one shared SISO chain: captures a granted word,
// shifts it out MSB-first, flushes DEPTH zeros, then pulses done.
module siso_sched
  import siso_pkg::*;
#(
  parameter  int NREQ  = 4,
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int IW    = cnt_width(NREQ),
  localparam int BW    = cnt_width(WIDTH),
  localparam int FW    = cnt_width(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic                  s_in,
  output logic                  shift_en,
  output logic                  busy,
  output logic [IW-1:0]         grant_id,
  output logic                  done
);

  state_t           state, state_next;
  logic [WIDTH-1:0] shadow;
  logic [WIDTH-1:0] word_sel;
  logic [BW-1:0]    bit_cnt;
  logic [FW-1:0]    flush_cnt;
  logic [IW-1:0]    last_grant;
  logic [NREQ-1:0]  arb_grant;
  logic [IW-1:0]    arb_idx;
  logic             handshake;
  logic             s_in_next;
  logic             shadow_bit;

  // req_ready is held low while reset is asserted so no handshake can be seen
  siso_rr_arb #(.NREQ(NREQ)) u_arb (
    .req_valid  (req_valid),
    .last_grant (last_grant),
    .enable     ((state == ST_IDLE) && rst),
    .grant      (arb_grant),
    .grant_idx  (arb_idx)
  );

  assign req_ready = arb_grant;
  assign handshake = |arb_grant;
  assign word_sel  = req_data[int'(arb_idx)*WIDTH +: WIDTH];

  // Next bit to present: shadow[bit_cnt-1], selected without a narrow index
  always_comb begin
    shadow_bit = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (BW'(i) == (bit_cnt - 1'b1)) begin
        shadow_bit = shadow[i];
      end else begin
        shadow_bit = shadow_bit;
      end
    end
  end

  // Next-state and next serial bit; FLUSH is bypassed for a zero-depth chain
  always_comb begin
    state_next = state;
    s_in_next  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (handshake) state_next = ST_SHIFT;
        else           state_next = ST_IDLE;
      end
      ST_SHIFT: begin
        if (bit_cnt == {BW{1'b0}}) state_next = (DEPTH > 0) ? ST_FLUSH : ST_DONE;
        else                       state_next = ST_SHIFT;
      end
      ST_FLUSH: begin
        if (flush_cnt == {FW{1'b0}}) state_next = ST_DONE;
        else                         state_next = ST_FLUSH;
      end
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
    case (state_next)
      ST_SHIFT: s_in_next = (state == ST_IDLE) ? word_sel[WIDTH-1] : shadow_bit;
      default:  s_in_next = 1'b0;
    endcase
  end

  // State register and registered chain-side outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      s_in     <= 1'b0;
      shift_en <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_next;
      s_in     <= s_in_next;
      shift_en <= (state_next == ST_SHIFT) || (state_next == ST_FLUSH);
      busy     <= (state_next != ST_IDLE);
      done     <= (state_next == ST_DONE);
    end
  end

  // Shadow capture, grant bookkeeping and the bit/flush counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow     <= {WIDTH{1'b0}};
      grant_id   <= {IW{1'b0}};
      last_grant <= IW'(NREQ - 1);
      bit_cnt    <= {BW{1'b0}};
      flush_cnt  <= {FW{1'b0}};
    end else if ((state == ST_IDLE) && handshake) begin
      shadow     <= word_sel;
      grant_id   <= arb_idx;
      last_grant <= arb_idx;
      bit_cnt    <= BW'(WIDTH - 1);
    end else if (state == ST_SHIFT) begin
      if (bit_cnt != {BW{1'b0}}) bit_cnt <= bit_cnt - 1'b1;
      else                       bit_cnt <= bit_cnt;
      flush_cnt <= FW'((DEPTH > 0) ? DEPTH - 1 : 0);
    end else if (state == ST_FLUSH) begin
      if (flush_cnt != {FW{1'b0}}) flush_cnt <= flush_cnt - 1'b1;
      else                         flush_cnt <= flush_cnt;
    end else begin
      shadow <= shadow;
    end
  end

endmodule

// File: doc/siso_sched.md
Name: siso_sched

Overview:
- Round-robin scheduler that shares one serial-in/serial-out shift chain between NREQ parallel requesters.
- Grants one requester at a time and captures its WIDTH-bit word.
- Drives the word MSB-first onto the chain's serial input with a shift enable.
- Then flushes DEPTH zero bits so the last data bit reaches the chain output, and pulses done.
- Sits between the requester blocks and the SISO datapath.

Parameters:
- NREQ, 4, number of requesters (2..8)
- WIDTH, 8, bits per word (>=1)
- DEPTH, 4, stage count of the downstream SISO chain (>=0); flush length in cycles

Ports:
- clk, input, 1, single clock; all state changes on posedge
- rst, input, 1, asynchronous, active-low reset (0 = reset asserted)
- req_valid, input, NREQ, per-requester word-available flag
- req_data, input, NREQ*WIDTH, requester i word at bits [i*WIDTH +: WIDTH]
- req_ready, output, NREQ, one-hot accept strobe; handshake when req_valid[i] & req_ready[i]
- s_in, output, 1, serial bit to the SISO chain input
- shift_en, output, 1, shift enable to the SISO chain
- busy, output, 1, high in every non-IDLE state
- grant_id, output, clog2(NREQ), index of the requester being served; holds its last value when idle
- done, output, 1, one-cycle pulse when a word has fully propagated through the chain

Behaviour:
- Reset (rst=0, async): state=IDLE; s_in, shift_en, busy, done, req_ready = 0; grant_id=0; last_grant=NREQ-1 so requester 0 has first priority.
- Reset asserted mid-operation aborts immediately. Captured word is discarded, no done is issued, and no handshake is completed.
- States: IDLE -> SHIFT -> FLUSH -> DONE -> IDLE.
  - FLUSH is skipped when DEPTH=0 (SHIFT -> DONE).
- IDLE:
  - req_ready is combinational from state, last_grant and req_valid only.
  - Exactly one bit is set: the first valid requester scanning from (last_grant+1) mod NREQ upward with wrap.
  - req_ready is all zeros if no requester is valid, and all zeros outside IDLE.
  - On a handshake at edge T: capture the word into shadow, set grant_id and last_grant, set bit_cnt=WIDTH-1, go to SHIFT.
- SHIFT:
  - shift_en=1, s_in=shadow[bit_cnt], decrement bit_cnt each cycle.
  - Lasts exactly WIDTH cycles; first data bit is valid in the cycle after edge T.
- FLUSH: shift_en=1, s_in=0, for exactly DEPTH cycles (flush counter).
- DONE: shift_en=0, s_in=0, done=1 for one cycle, then IDLE.
- Cycle accounting for a handshake at edge T:
  - SHIFT occupies cycles T+1..T+WIDTH.
  - FLUSH occupies T+WIDTH+1..T+WIDTH+DEPTH.
  - done occurs at T+WIDTH+DEPTH+1.
  - The earliest next handshake is at the edge ending the following IDLE cycle.
- Output decode:
  - s_in, shift_en, busy, done and grant_id are driven from registers only (no combinational input path).
  - s_in and shift_en are 0 whenever state is IDLE or DONE.
- Requester rules:
  - A requester may drop req_valid at any time before its handshake; the arbiter re-evaluates every IDLE cycle.
  - req_data is sampled only at the handshake edge.
- Simultaneous valids: strictly round-robin. A requester served last has lowest priority next time. A single valid requester may be served repeatedly.
- Counters:
  - bit_cnt is clog2(WIDTH) bits wide, minimum 1.
  - The flush counter is clog2(DEPTH+1) bits wide.
  - No counter wraps; terminal count triggers the state change.

Decomposition:
- Shared package/header siso_pkg:
  - state encoding constants ST_IDLE, ST_SHIFT, ST_FLUSH, ST_DONE (2-bit)
  - width helper constants derived from NREQ, WIDTH, DEPTH
- One sub-module: siso_rr_arb (NREQ).
  - Inputs: req_valid, last_grant, enable.
  - Outputs: one-hot grant and encoded grant index.
  - Purely combinational rotate-priority-rotate.
- siso_sched holds the FSM, shadow register and counters.

Test Plan:
- Reset then single request: rst=0 for 10 ns, release, req_valid=4'b0001, req_data[7:0]=8'hB3 -> handshake on first IDLE edge; s_in sequence 1,0,1,1,0,0,1,1 with shift_en=1; then 4 cycles s_in=0, shift_en=1; then done=1 for exactly one cycle; grant_id=0.
- Round-robin fairness: all four valid continuously, words 8'h11/8'h22/8'h33/8'h44 -> grants in order 0,1,2,3,0; each separated by WIDTH+DEPTH+2 = 14 cycles; req_ready never multi-hot.
- Priority wrap: after serving requester 3, assert req_valid=4'b1001 -> requester 0 granted; then req_valid=4'b1001 again -> requester 3 granted.
- Mid-operation reset: assert rst=0 during the 5th SHIFT cycle -> s_in, shift_en, busy drop within the same cycle (async); no done pulse; after release requester 0 again has top priority.
- DEPTH=0 build, WIDTH=1: req_valid=4'b0100, data bit 1 -> one SHIFT cycle with s_in=1, done on the next cycle, no FLUSH cycles.
- Valid withdrawn: req_valid[2] pulsed for one cycle while busy, then dropped -> never granted; busy returns to 0 and req_ready stays 0.
